// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// slice width and the nibble-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Width of the nibble counter; never narrower than one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/claadder.sv
// 4-bit carry-lookahead adder slice: all carries are computed in parallel
// from generate/propagate terms rather than rippled.
module claadder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a single 4-bit CLA slice.
// Operands are consumed one nibble per cycle, LSB first, with the carry
// held in a register between cycles; the sum is assembled MSB-first into
// a right-shifting register so it lands aligned after the last nibble.
// Optional feature: define SERIAL_ADD_OVF_EN to add the out_ovf port
// (signed two's-complement overflow flag).
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_e               state_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [WIDTH-1:0]     a_d, b_d, sum_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_cout;

`ifdef SERIAL_ADD_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  claadder u_slice (
    .A    (a_q[NIBBLE_W-1:0]),
    .B    (b_q[NIBBLE_W-1:0]),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  // Next values of the shifting datapath registers during RUN.
  always_comb begin
    a_d   = a_q >> NIBBLE_W;
    b_d   = b_q >> NIBBLE_W;
    sum_d = {slice_s, sum_q[WIDTH-1:NIBBLE_W]};
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Sequencer and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            a_msb_q <= in_a[WIDTH-1];
            b_msb_q <= in_b[WIDTH-1];
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= slice_cout;
          sum_q   <= sum_d;
          a_q     <= a_d;
          b_q     <= b_d;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST_CNT) begin
            // Final nibble: its carry-out and sum MSB complete the result.
            cout_q  <= slice_cout;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= (a_msb_q == b_msb_q) && (slice_s[NIBBLE_W-1] != a_msb_q);
`endif
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and status outputs depend on the state register alone.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): directed operands
// with hand-computed results are queued at accept and checked by an
// independent monitor on every output handshake.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             out_ovf;
`endif

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every result handshake pops and compares one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("sum",  out_sum,  e.sum);
        chk("cout", out_cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf",  out_ovf,  e.ovf);
`endif
      end
    end
  end

  // Present operands until accepted; queue the expected result. Returns the
  // accept edge index. Called at posedge+1.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic [WIDTH-1:0] es,
                       input logic ec, input logic eo, output int acc);
    exp_t e;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.sum = es; e.cout = ec; e.ovf = eo;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Accept results until the scoreboard has been emptied.
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    out_ready = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk("out_valid_timeout", out_valid, 1);
  endtask

  initial begin
    int acc, acc1, acc2, acc3, hs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_cout",  out_cout,  0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_out_ovf",   out_ovf,   0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add with latency and status checks
    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, acc);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        chk("run_in_ready",  in_ready,  0);
        chk("run_busy",      busy,      1);
        chk("run_out_valid", out_valid, 0);
      end else begin
        chk("latency_out_valid", out_valid, 1);
        chk("done_busy",         busy,      1);
      end
    end
    @(posedge clk);
    #1;
    drain();

    // Carry chained through every nibble
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
    drain();
    issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, acc);
    drain();

    // Backpressure in DONE with new operands waiting
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, acc);
    wait_valid();
    @(posedge clk);
    #1;
    in_a = 16'h0F0F; in_b = 16'h0101; in_cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum",   out_sum,   16'h3333);
      chk("bp_out_cout",  out_cout,  0);
      chk("bp_in_ready",  in_ready,  0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    hs = cyc + 1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, acc);
    chk("accept_after_idle", acc, hs + 1);
    drain();

    // Reset in the second RUN cycle abandons the operation
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  in_ready,  1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy",      busy,      0);
    chk("mid_rst_out_sum",   out_sum,   0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, acc);
    drain();

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, acc1);
    issue(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, acc2);
    issue(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0, acc3);
    drain();
    chk("b2b_spacing_1", acc2 - acc1, NIBBLES + 2);
    chk("b2b_spacing_2", acc3 - acc2, NIBBLES + 2);

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, acc);
    drain();
    issue(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, acc);
    drain();
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
